// File: rtl/lsu_mem_stage_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
// Request side is registered by the master; ack/rdata are sampled while bus_req is high.
interface lsu_mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: store lane/byte-enable formatting, load extension; LSU_MISALIGN_TRAP_EN adds a misalign trap.
// Latency: IDLE -> BUSY (until ack or TIMEOUT) -> DONE, minimum 3 cycles per access.
// Backpressure: stall holds the pipeline through the IDLE request cycle and every BUSY cycle.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    lsu_mem_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic [31:0] ldata_q;
    logic        valid_q;
    logic        err_q;

    logic        access;
    logic        timeout_hit;
    logic [31:0] st_wdata_d;
    logic [3:0]  st_be_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt_d;

    assign access      = mem_rd | mem_wr;
    assign cnt_d       = cnt_q + 8'd1;
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    // A request with both mem_rd and mem_wr set is a store.
    always_comb begin
        st_wdata_d = wdata;
        st_be_d    = 4'b1111;
        case (funct3)
            3'b000, 3'b100: begin
                st_wdata_d = {4{wdata[7:0]}};
                st_be_d    = 4'b0001 << addr[1:0];
            end
            3'b001, 3'b101: begin
                st_wdata_d = {2{wdata[15:0]}};
                st_be_d    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte  = bus.bus_rdata[{off_q, 3'b000} +: 8];
        ld_half  = bus.bus_rdata[{off_q[1], 4'b0000} +: 16];
        ld_fmt_d = bus.bus_rdata;
        case (f3_q)
            3'b000:  ld_fmt_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt_d = {24'h0, ld_byte};
            3'b001:  ld_fmt_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt_d = {16'h0, ld_half};
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_d;
    logic mis_q;

    always_comb begin
        mis_d = 1'b0;
        case (funct3)
            3'b000, 3'b100: mis_d = 1'b0;
            3'b001, 3'b101: mis_d = addr[0];
            default:        mis_d = |addr[1:0];
        endcase
    end

    assign misalign = mis_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
            ldata_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (access) begin
                        addr_q    <= {addr[31:2], 2'b00};
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        is_load_q <= ~mem_wr;
                        we_q      <= mem_wr;
                        wdata_q   <= mem_wr ? st_wdata_d : 32'h0;
                        be_q      <= mem_wr ? st_be_d : 4'h0;
                        cnt_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (mis_d) begin
                            mis_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= BUSY;
                        end
`else
                        req_q   <= 1'b1;
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    if (bus.bus_ack) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        if (is_load_q) begin
                            ldata_q <= ld_fmt_d;
                            valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Aborted loads still retire, with a zero result flagged by bus_err.
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        ldata_q <= '0;
                        valid_q <= is_load_q;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gates stall so a held request cannot freeze the pipeline during reset.
    assign stall = ~rst & (((state_q == IDLE) & access) | (state_q == BUSY));

    assign load_data     = ldata_q;
    assign load_valid    = valid_q;
    assign bus_err       = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage (TIMEOUT=4); each access is driven to DONE and one cycle past it.
module tb_lsu_mem_stage;
    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
    logic        r_dmis;
    logic        r_post_mis;
`endif

    lsu_mem_stage_if bus_if ();

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bus_err    (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .bus        (bus_if)
    );

    int checks = 0;
    int errors = 0;

    int          r_stall;
    int          r_busy;
    logic        r_hung;
    logic        r_early_valid;
    logic        r_unstable;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_dvalid;
    logic        r_derr;
    logic        r_dreq;
    logic [31:0] r_ddata;
    logic        r_post_req;
    logic        r_post_valid;
    logic        r_post_err;
    logic        seen_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access from an IDLE cycle, acks in BUSY cycle ack_at (0 = never),
    // records what was seen up to DONE and one cycle after it.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata);
        bit done;
        done          = 1'b0;
        r_stall       = 0;
        r_busy        = 0;
        r_early_valid = 1'b0;
        r_unstable    = 1'b0;
        r_we          = 1'b0;
        r_addr        = 32'h0;
        r_wdata       = 32'h0;
        r_be          = 4'h0;
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                r_stall++;
                if (load_valid) r_early_valid = 1'b1;
                if (bus_if.bus_req) begin
                    r_busy++;
                    if (r_busy == 1) begin
                        r_addr = bus_if.bus_addr; r_wdata = bus_if.bus_wdata;
                        r_be = bus_if.bus_be; r_we = bus_if.bus_we;
                    end else if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_be, bus_if.bus_we}
                                 !== {r_addr, r_wdata, r_be, r_we}) begin
                        r_unstable = 1'b1;
                    end
                    if (r_busy == ack_at) begin
                        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
                    end
                end
                @(posedge clk); #1;
                bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
            end
        end
        r_hung   = !done;
        r_dvalid = load_valid;
        r_derr   = bus_err;
        r_ddata  = load_data;
        r_dreq   = bus_if.bus_req;
`ifdef LSU_MISALIGN_TRAP_EN
        r_dmis   = misalign;
`endif
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        r_post_req   = bus_if.bus_req;
        r_post_valid = load_valid;
        r_post_err   = bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
        r_post_mis   = misalign;
`endif
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        #2;
        check("rst_bus_req",    bus_if.bus_req,   0);
        check("rst_bus_we",     bus_if.bus_we,    0);
        check("rst_bus_addr",   bus_if.bus_addr,  0);
        check("rst_bus_wdata",  bus_if.bus_wdata, 0);
        check("rst_bus_be",     bus_if.bus_be,    0);
        check("rst_load_data",  load_data,        0);
        check("rst_load_valid", load_valid,       0);
        check("rst_bus_err",    bus_err,          0);
        check("rst_stall",      stall,            0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // SB, ack in second BUSY cycle
        access(1'b0, 1'b1, 3'b000, 32'h0000_1002, 32'h0000_00AB, 2, 32'h0);
        check("sb_hung",     r_hung,     0);
        check("sb_addr",     r_addr,     32'h0000_1000);
        check("sb_wdata",    r_wdata,    32'hABAB_ABAB);
        check("sb_be",       r_be,       4'b0100);
        check("sb_we",       r_we,       1);
        check("sb_stall",    r_stall,    3);
        check("sb_busy",     r_busy,     2);
        check("sb_stable",   r_unstable, 0);
        check("sb_dreq",     r_dreq,     0);
        check("sb_valid",    r_dvalid | r_early_valid | r_post_valid, 0);
        check("sb_post_req", r_post_req, 0);

        // SH upper half
        access(1'b0, 1'b1, 3'b001, 32'h0000_1006, 32'h1234_BEEF, 1, 32'h0);
        check("sh_addr",  r_addr,  32'h0000_1004);
        check("sh_wdata", r_wdata, 32'hBEEF_BEEF);
        check("sh_be",    r_be,    4'b1100);
        check("sh_stall", r_stall, 2);

        // LB / LBU from byte 3
        access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 1, 32'h80FF_FF7F);
        check("lb_hung",       r_hung,       0);
        check("lb_addr",       r_addr,       32'h0000_2000);
        check("lb_be",         r_be,         4'b0000);
        check("lb_we",         r_we,         0);
        check("lb_data",       r_ddata,      32'hFFFF_FF80);
        check("lb_valid",      r_dvalid,     1);
        check("lb_early",      r_early_valid, 0);
        check("lb_post_valid", r_post_valid, 0);
        check("lb_err",        r_derr,       0);
        access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 1, 32'h80FF_FF7F);
        check("lbu_data",  r_ddata,  32'h0000_0080);
        check("lbu_valid", r_dvalid, 1);

        // LH upper, LHU lower, LW
        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 32'h8001_1234);
        check("lh_data", r_ddata, 32'hFFFF_8001);
        access(1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 2, 32'h8001_1234);
        check("lhu_data",  r_ddata, 32'h0000_1234);
        check("lhu_stall", r_stall, 3);
        access(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 1, 32'h8001_1234);
        check("lw_data",  r_ddata, 32'h8001_1234);
        check("lw_stall", r_stall, 2);
`ifndef LSU_MISALIGN_TRAP_EN
        // Misaligned word completes at the aligned address
        access(1'b1, 1'b0, 3'b010, 32'h0000_2001, 32'h0, 1, 32'h5566_7788);
        check("mlw_addr", r_addr,  32'h0000_2000);
        check("mlw_data", r_ddata, 32'h5566_7788);
`endif

        // Timeout on a load (TIMEOUT=4)
        access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 0, 32'h0);
        check("to_hung",     r_hung,     0);
        check("to_busy",     r_busy,     4);
        check("to_stall",    r_stall,    5);
        check("to_dreq",     r_dreq,     0);
        check("to_err",      r_derr,     1);
        check("to_data",     r_ddata,    32'h0);
        check("to_valid",    r_dvalid,   1);
        check("to_post_err", r_post_err, 0);

        // Back-to-back SW then LW
        access(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0);
        check("b2b_sw_wdata",    r_wdata,    32'hDEAD_BEEF);
        check("b2b_sw_be",       r_be,       4'b1111);
        check("b2b_sw_stall",    r_stall,    2);
        check("b2b_sw_post_req", r_post_req, 0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 1, 32'h0BAD_F00D);
        check("b2b_lw_stall", r_stall,  2);
        check("b2b_lw_data",  r_ddata,  32'h0BAD_F00D);
        check("b2b_lw_valid", r_dvalid, 1);

        // mem_rd and mem_wr together act as a store
        access(1'b1, 1'b1, 3'b010, 32'h0000_4004, 32'h1357_9BDF, 1, 32'hFFFF_FFFF);
        check("rw_we",    r_we,     1);
        check("rw_be",    r_be,     4'b1111);
        check("rw_wdata", r_wdata,  32'h1357_9BDF);
        check("rw_valid", r_dvalid, 0);
        check("rw_data",  r_ddata,  32'h0BAD_F00D);

        // Reset in the middle of a load
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
        @(posedge clk); #1;
        check("mid_pre_req", bus_if.bus_req, 1);
        rst = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        #1;
        check("mid_req",   bus_if.bus_req,  0);
        check("mid_stall", stall,           0);
        check("mid_addr",  bus_if.bus_addr, 0);
        check("mid_data",  load_data,       0);
        @(posedge clk); #1;
        mem_rd = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0; rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (load_valid || bus_if.bus_req) seen_valid = 1'b1;
        end
        check("mid_no_valid", seen_valid, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'hDEAD_0000);
        check("mis_busy",     r_busy,     0);
        check("mis_stall",    r_stall,    1);
        check("mis_pulse",    r_dmis,     1);
        check("mis_valid",    r_dvalid,   0);
        check("mis_post",     r_post_mis, 0);
        check("mis_post_req", r_post_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
